// File: rtl/prng_scheduler.sv
// ============================================================================
// Module   : prng_scheduler
// Brief    : Shared 6-bit Fibonacci LFSR, round-robin granted to requesters,
//            with seed loading and a timed stir burst.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module prng_scheduler #(
    parameter int N_REQ      = 4,
    parameter int STIR_STEPS = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [2:0]       rnd,
    output logic             rnd_valid,
    input  logic             seed_load,
    input  logic [5:0]       seed_val,
    input  logic             stir,
    output logic             busy
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_grant = 2'd1;
    localparam logic [1:0] c_stir  = 2'd2;

    localparam logic [7:0]       c_stir_last = 8'(STIR_STEPS - 1);
    localparam logic [PW-1:0]    c_last_req  = PW'(N_REQ - 1);
    localparam logic [PW:0]      c_nreq      = (PW + 1)'(N_REQ);
    localparam logic [N_REQ-1:0] c_one       = N_REQ'(1);

    logic [1:0]    r_state;
    logic [1:0]    w_next_state;
    logic [5:0]    r_lfsr;
    logic [PW-1:0] r_rr_ptr;
    logic [PW-1:0] r_winner;
    logic          r_stir_pend;
    logic [7:0]    r_cnt;
    logic [2:0]    r_rnd_hold;

    logic [5:0]    w_lfsr_step;
    logic [5:0]    w_seed;
    logic [2:0]    w_map;
    logic          w_any_req;
    logic [PW-1:0] w_arb_winner;
    logic [PW:0]   w_sum;

    assign w_lfsr_step = {r_lfsr[4:0], r_lfsr[5] ^ r_lfsr[4]};
    assign w_seed      = (seed_val == 6'd0) ? 6'd1 : seed_val;
    assign w_map       = {r_lfsr[1], r_lfsr[3], r_lfsr[5]};
    assign w_any_req   = |req;

    // Rotating search: first set request at or above rr_ptr, wrapping.
    always_comb begin
        w_arb_winner = '0;
        w_sum        = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            w_sum = {1'b0, r_rr_ptr} + (PW + 1)'(i);
            if (w_sum >= c_nreq) begin
                w_sum = w_sum - c_nreq;
            end
            if (req[w_sum[PW-1:0]]) begin
                w_arb_winner = w_sum[PW-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_idle: begin
                if (seed_load) begin
                    w_next_state = c_idle;
                end else if (stir || r_stir_pend) begin
                    w_next_state = c_stir;
                end else if (w_any_req) begin
                    w_next_state = c_grant;
                end
            end
            c_grant: w_next_state = c_idle;
            c_stir: begin
                if (seed_load || (r_cnt == 8'd0)) begin
                    w_next_state = c_idle;
                end
            end
            default: w_next_state = c_idle;
        endcase
    end

    always_comb begin
        gnt       = '0;
        rnd_valid = 1'b0;
        rnd       = r_rnd_hold;
        busy      = r_stir_pend;
        case (r_state)
            c_grant: begin
                gnt       = c_one << r_winner;
                rnd_valid = 1'b1;
                rnd       = w_map;
            end
            c_stir:  busy = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_lfsr      <= 6'd1;
            r_rr_ptr    <= '0;
            r_winner    <= '0;
            r_stir_pend <= 1'b0;
            r_cnt       <= 8'd0;
            r_rnd_hold  <= 3'd0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (seed_load) begin
                        r_lfsr <= w_seed;
                        // A coincident stir is remembered rather than dropped.
                        if (stir) begin
                            r_stir_pend <= 1'b1;
                        end
                    end else if (stir || r_stir_pend) begin
                        r_cnt       <= c_stir_last;
                        r_stir_pend <= 1'b0;
                    end else if (w_any_req) begin
                        r_winner <= w_arb_winner;
                    end
                end
                c_grant: begin
                    r_lfsr     <= seed_load ? w_seed : w_lfsr_step;
                    r_rnd_hold <= w_map;
                    r_rr_ptr   <= (r_winner == c_last_req) ? '0 : r_winner + 1'b1;
                    if (stir) begin
                        r_stir_pend <= 1'b1;
                    end
                end
                c_stir: begin
                    if (seed_load) begin
                        r_lfsr      <= w_seed;
                        r_stir_pend <= 1'b0;
                    end else begin
                        r_lfsr <= w_lfsr_step;
                        r_cnt  <= r_cnt - 8'd1;
                        if (stir) begin
                            r_stir_pend <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_prng_scheduler.sv
// ============================================================================
// Module   : tb_prng_scheduler
// Brief    : Scoreboard bench for prng_scheduler with an LFSR reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_prng_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] req = 4'd0;
    logic [3:0] gnt;
    logic [2:0] rnd;
    logic       rnd_valid;
    logic       seed_load = 1'b0;
    logic [5:0] seed_val = 6'd0;
    logic       stir = 1'b0;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic [3:0] g;
        logic [2:0] r;
    } exp_t;

    exp_t       sb_q[$];
    exp_t       mon_e;
    logic [5:0] m_lfsr = 6'd1;

    prng_scheduler #(.N_REQ(4), .STIR_STEPS(7)) dut (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt), .rnd(rnd),
        .rnd_valid(rnd_valid), .seed_load(seed_load), .seed_val(seed_val),
        .stir(stir), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] m_step(input logic [5:0] s);
        return {s[4:0], s[5] ^ s[4]};
    endfunction

    function automatic logic [2:0] m_map(input logic [5:0] s);
        return {s[1], s[3], s[5]};
    endfunction

    // Record an expected grant and advance the reference LFSR.
    task automatic push_grant(input logic [3:0] g);
        exp_t e;
        e.g = g;
        e.r = m_map(m_lfsr);
        sb_q.push_back(e);
        m_lfsr = m_step(m_lfsr);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            n_checks++;
            if (rnd_valid !== (gnt != 4'd0)) begin
                n_errors++;
                $display("FAIL valid_align: rnd_valid=%b gnt=%b, required rnd_valid == |gnt", rnd_valid, gnt);
            end
            if (rnd_valid === 1'b1) begin
                n_checks++;
                if (sb_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL sb_unexpected: gnt=%b rnd=%b, required no grant", gnt, rnd);
                end else begin
                    mon_e = sb_q.pop_front();
                    if ({gnt, rnd} !== {mon_e.g, mon_e.r}) begin
                        n_errors++;
                        $display("FAIL sb_grant: gnt=%b rnd=%b, required gnt=%b rnd=%b", gnt, rnd, mon_e.g, mon_e.r);
                    end
                end
            end
        end
    end

    task automatic do_reset();
        rst       = 1'b0;
        req       = 4'd0;
        stir      = 1'b0;
        seed_load = 1'b0;
        seed_val  = 6'd0;
        repeat (2) @(negedge clk);
        rst    = 1'b1;
        m_lfsr = 6'd1;
        sb_q.delete();
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(negedge clk);
        n_checks++;
        if (sb_q.size() != 0) begin
            n_errors++;
            $display("FAIL %s_drain: %0d grants outstanding, required 0", name, sb_q.size());
        end
    endtask

    task automatic single_grant(input logic [3:0] r, output logic [2:0] got);
        push_grant(r);
        req = r;
        @(negedge clk);
        n_checks++;
        if (rnd_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL single_grant_valid: rnd_valid=%b, required 1", rnd_valid);
        end
        got = rnd;
        req = 4'd0;
        @(negedge clk);
        n_checks++;
        if (rnd_valid !== 1'b0 || rnd !== got) begin
            n_errors++;
            $display("FAIL rnd_hold: rnd_valid=%b rnd=%b, required 0 and %b", rnd_valid, rnd, got);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++;
        if ({gnt, rnd, rnd_valid, busy} !== 9'd0) begin
            n_errors++;
            $display("FAIL reset_outputs: gnt=%b rnd=%b v=%b busy=%b, required all 0", gnt, rnd, rnd_valid, busy);
        end
        do_reset();
        @(negedge clk);
        n_checks++;
        if ({gnt, rnd, rnd_valid, busy} !== 9'd0) begin
            n_errors++;
            $display("FAIL reset_idle: gnt=%b rnd=%b v=%b busy=%b, required all 0", gnt, rnd, rnd_valid, busy);
        end
    endtask

    task automatic test_single_requester();
        logic [2:0] exp_rnd [6] = '{3'b000, 3'b100, 3'b000, 3'b010, 3'b000, 3'b001};
        exp_t e;
        do_reset();
        for (int k = 0; k < 6; k++) begin
            e.g = 4'b0001;
            e.r = exp_rnd[k];
            sb_q.push_back(e);
            m_lfsr = m_step(m_lfsr);
        end
        req = 4'b0001;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            n_checks++;
            if (rnd_valid !== (c % 2 == 0)) begin
                n_errors++;
                $display("FAIL single_cadence: cycle %0d rnd_valid=%b, required %b", c, rnd_valid, (c % 2 == 0));
            end
            if (c == 11) req = 4'd0;
        end
        @(negedge clk);
        n_checks++;
        if (rnd_valid !== 1'b0 || rnd !== 3'b001) begin
            n_errors++;
            $display("FAIL single_hold: rnd_valid=%b rnd=%b, required 0 and 001", rnd_valid, rnd);
        end
        wait_drain("single");
    endtask

    task automatic test_round_robin();
        logic [3:0] order [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        do_reset();
        for (int k = 0; k < 5; k++) push_grant(order[k]);
        req = 4'b1111;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_checks++;
            if (rnd_valid !== (c % 2 == 0) || $countones(gnt) > 1) begin
                n_errors++;
                $display("FAIL rr_cadence: cycle %0d rnd_valid=%b gnt=%b, required valid=%b one-hot", c, rnd_valid, gnt, (c % 2 == 0));
            end
            if (c == 9) req = 4'd0;
        end
        wait_drain("rr");
    endtask

    task automatic load_seed(input logic [5:0] s);
        seed_val  = s;
        seed_load = 1'b1;
        @(negedge clk);
        seed_load = 1'b0;
        m_lfsr    = (s == 6'd0) ? 6'd1 : s;
    endtask

    task automatic test_seed();
        logic [2:0] got;
        load_seed(6'd0);
        single_grant(4'b0001, got);
        n_checks++;
        if (got !== 3'b000) begin
            n_errors++;
            $display("FAIL seed_zero: rnd=%b, required 000", got);
        end
        single_grant(4'b0001, got);
        n_checks++;
        if (got !== 3'b100) begin
            n_errors++;
            $display("FAIL seed_zero_next: rnd=%b, required 100", got);
        end
        load_seed(6'h3F);
        single_grant(4'b0100, got);
        n_checks++;
        if (got !== 3'b111) begin
            n_errors++;
            $display("FAIL seed_3f: rnd=%b, required 111", got);
        end
        wait_drain("seed");
    endtask

    task automatic test_stir();
        int cnt;
        logic [2:0] got;
        do_reset();
        for (int k = 0; k < 7; k++) m_lfsr = m_step(m_lfsr);
        push_grant(4'b0001);
        stir = 1'b1;
        @(negedge clk);
        stir = 1'b0;
        req  = 4'b0001;
        cnt  = 0;
        while (busy === 1'b1 && cnt < 20) begin
            n_checks++;
            if (rnd_valid !== 1'b0) begin
                n_errors++;
                $display("FAIL stir_no_grant: rnd_valid=%b during burst, required 0", rnd_valid);
            end
            cnt++;
            @(negedge clk);
        end
        n_checks++;
        if (cnt != 7) begin
            n_errors++;
            $display("FAIL stir_busy_len: busy cycles=%0d, required 7", cnt);
        end
        @(negedge clk);
        n_checks++;
        if (rnd_valid !== 1'b1 || rnd !== 3'b100) begin
            n_errors++;
            $display("FAIL stir_grant: rnd_valid=%b rnd=%b, required 1 and 100", rnd_valid, rnd);
        end
        got = rnd;
        req = 4'd0;
        @(negedge clk);
        wait_drain("stir");
    endtask

    task automatic test_stir_pending();
        logic [2:0] got;
        push_grant(4'b0001);
        req = 4'b0001;
        @(negedge clk);
        n_checks++;
        if (rnd_valid !== 1'b1 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL pend_grant: rnd_valid=%b busy=%b, required 1 and 0", rnd_valid, busy);
        end
        stir = 1'b1;
        req  = 4'd0;
        @(negedge clk);
        stir = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || rnd_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL pend_busy: busy=%b rnd_valid=%b, required 1 and 0", busy, rnd_valid);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (busy !== 1'b1) begin
            n_errors++;
            $display("FAIL pend_burst: busy=%b, required 1", busy);
        end
        seed_val  = 6'h2A;
        seed_load = 1'b1;
        @(negedge clk);
        seed_load = 1'b0;
        m_lfsr    = 6'h2A;
        n_checks++;
        if (busy !== 1'b0) begin
            n_errors++;
            $display("FAIL stir_abort: busy=%b, required 0", busy);
        end
        single_grant(4'b0001, got);
        n_checks++;
        if (got !== 3'b111) begin
            n_errors++;
            $display("FAIL abort_seed: rnd=%b, required 111", got);
        end
        wait_drain("pend");
    endtask

    task automatic test_async_reset();
        logic [2:0] got;
        push_grant(4'b0001);
        req = 4'b0001;
        @(negedge clk);
        n_checks++;
        if (rnd_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL areset_pre: rnd_valid=%b, required 1", rnd_valid);
        end
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if ({gnt, rnd_valid, busy, rnd} !== 9'd0) begin
            n_errors++;
            $display("FAIL areset_grant: gnt=%b v=%b busy=%b rnd=%b, required all 0", gnt, rnd_valid, busy, rnd);
        end
        @(negedge clk);
        req    = 4'd0;
        rst    = 1'b1;
        m_lfsr = 6'd1;
        sb_q.delete();
        single_grant(4'b0010, got);
        n_checks++;
        if (got !== 3'b000) begin
            n_errors++;
            $display("FAIL areset_lfsr0: rnd=%b, required 000", got);
        end
        single_grant(4'b0010, got);
        n_checks++;
        if (got !== 3'b100) begin
            n_errors++;
            $display("FAIL areset_lfsr1: rnd=%b, required 100", got);
        end
        stir = 1'b1;
        @(negedge clk);
        stir = 1'b0;
        n_checks++;
        if (busy !== 1'b1) begin
            n_errors++;
            $display("FAIL areset_stir_pre: busy=%b, required 1", busy);
        end
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0) begin
            n_errors++;
            $display("FAIL areset_stir: busy=%b, required 0", busy);
        end
        @(negedge clk);
        rst    = 1'b1;
        m_lfsr = 6'd1;
        wait_drain("areset");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_requester();
        test_round_robin();
        test_seed();
        test_stir();
        test_stir_pending();
        test_async_reset();
        n_checks++;
        if (sb_q.size() != 0) begin
            n_errors++;
            $display("FAIL sb_final: %0d grants outstanding, required 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/prng_scheduler.md
Name: prng_scheduler

Overview:
Owns the 6-bit Fibonacci LFSR random source and shares it between N requesters, such as dither and noise/snow effect generators in the video pipeline. Requesters are served round-robin, one 3-bit random value per grant. The LFSR advances exactly one step per grant, so no two consumers ever receive the same sample. It also handles seed loading and a timed "stir" burst, intended for vertical blank, that decorrelates frames.

Parameters:
N_REQ, 4, number of requesters (2..8)
STIR_STEPS, 7, LFSR steps per stir burst (1..255)

Ports:
clk  in  1  system clock, all logic rising-edge
rst  in  1  reset, asynchronous, active-low
req  in  N_REQ  per-requester request, level, held until granted
gnt  out  N_REQ  one-hot grant, one-cycle pulse
rnd  out  3  random value delivered with gnt
rnd_valid  out  1  high in the same cycle as any gnt bit
seed_load  in  1  one-cycle pulse: load seed_val into LFSR
seed_val  in  6  seed value
stir  in  1  one-cycle pulse: start stir burst
busy  out  1  high while stir burst is active or a stir is pending

Behaviour:
- Reset (rst low, async): lfsr=6'd1, gnt=0, rnd=0, rnd_valid=0, busy=0, rr_ptr=0, stir_pend=0, state=IDLE.
- LFSR step: lfsr <= {lfsr[4:0], lfsr[5]^lfsr[4]}. Period is 63. The all-zero state is unreachable.
- Output mapping: rnd = {lfsr[1], lfsr[3], lfsr[5]}, taken from the lfsr value before the step that accompanies the grant.
- States: IDLE, GRANT, STIR.
- Priority in IDLE each cycle: seed_load > (stir or stir_pend) > req.
- seed_load: lfsr <= (seed_val==0) ? 6'd1 : seed_val. State stays IDLE. Requests are not evaluated in that cycle.
- Stir: goes to STIR with cnt=STIR_STEPS-1 and busy=1. The LFSR steps every cycle in STIR. When cnt==0 on a step, the state returns to IDLE and busy drops on the following cycle. The burst therefore performs exactly STIR_STEPS steps. No grants are issued during STIR.
- Request: the winner is the first set req bit searching from rr_ptr upward, wrapping modulo N_REQ. On the next edge the state goes to GRANT, and during GRANT:
  - gnt[winner]=1, rnd=mapping(lfsr), rnd_valid=1;
  - lfsr steps once;
  - rr_ptr=(winner+1) mod N_REQ.
- GRANT always returns to IDLE after one cycle. Grant latency from req rising in IDLE is 1 cycle. Peak throughput is one grant per 2 cycles.
- Requesters must drop req on the cycle after gnt. A req still high in IDLE is treated as a new request.
- rnd holds its last value when rnd_valid=0. gnt and rnd_valid are 0 outside GRANT.
- stir arriving in GRANT or STIR sets stir_pend, which is serviced at the next IDLE. busy is high while stir_pend=1. Pulses while pending merge into one burst.
- seed_load in GRANT: the grant completes with its pre-load rnd, and the seed load overrides the step.
- seed_load in STIR: aborts the burst, loads the seed, clears stir_pend, and returns to IDLE.
- rst low mid-grant or mid-stir: all state returns to reset values immediately. No grant pulse survives.

Test Plan:
- Reset then single requester req[0] held, 6 grants: rnd sequence is 000,100,000,010,000,001 (lfsr 01,02,04,08,10,21 hex). Grants come every 2nd cycle.
- req=4'b1111 held continuously: gnt order is 0001,0010,0100,1000,0001. rnd_valid coincides with each gnt. No cycle has 2 grant bits set.
- seed_load with seed_val=0, then one grant: rnd=000 and the next lfsr is 02, proving 0 is replaced by 1. Then seed_val=6'h3F and a grant: rnd=111.
- From reset, stir with STIR_STEPS=7: busy is high for 7 STIR cycles, a req asserted during the burst is granted only after busy falls, and that grant's rnd is mapping(lfsr after 7 steps from 01).
- stir pulsed during GRANT: stir_pend is set, busy rises, and the burst runs after the grant. Then seed_load during STIR: the burst aborts and the lfsr equals the seed.
- rst low asynchronously mid-GRANT: gnt, rnd_valid and busy go 0 without a clock edge, and lfsr=01 after release.
